pc_sequencer: RTL and testbench

//  Owns the program counter of the single-cycle core and sequences its updates.

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_next_mux.sv | 77 +++++++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
//   state_t  : sequencer FSM encoding, also driven out on the state port
//   cause_t  : exception cause codes held in the cause register
//   INSTR_BYTES : byte stride between sequential instructions
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_EXT      = 2'b01,
        CAUSE_MISALIGN = 2'b10
    } cause_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Combinational next-PC priority select with misaligned-target detection.
// Only meaningful while the sequencer is in RUN and not stalled; the top
// decides whether the result is used.
//   pc, epc          : current PC and saved exception PC
//   branch_*/jump*/jr* : redirect requests and their targets
//   exception, eret, halt : control events from the current instruction
//   next_pc          : PC to load on the coming edge
//   take_trap        : an exception (external or misaligned) is taken
//   trap_cause       : cause code to record when take_trap is set
//   enter_halt       : halt is taken (no exception this cycle)
//   clear_cause      : eret is the winning action, cause returns to none
module pc_sequencer_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic [31:0] pc,
    input  logic [31:0] epc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exception,
    input  logic        eret,
    input  logic        halt,
    output logic [31:0] next_pc,
    output logic        take_trap,
    output cause_t      trap_cause,
    output logic        enter_halt,
    output logic        clear_cause
);

    logic        redirect;
    logic [31:0] target;
    logic        misaligned;
    logic [31:0] seq_pc;

    // Among the target-carrying redirects jr beats jump beats branch; the
    // alignment check applies to whichever one would actually be taken.
    assign redirect   = jr | jump | branch_taken;
    assign target     = jr ? jr_target : (jump ? jump_target : branch_target);
    assign misaligned = redirect && (target[1:0] != 2'b00);
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 becomes 0 with no fault.
    assign seq_pc     = pc + INSTR_BYTES;

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves a value unassigned, which would infer a latch.
        next_pc     = seq_pc;
        take_trap   = 1'b0;
        trap_cause  = CAUSE_NONE;
        enter_halt  = 1'b0;
        clear_cause = 1'b0;

        if (exception) begin
            next_pc    = TRAP_VECTOR;
            take_trap  = 1'b1;
            trap_cause = CAUSE_EXT;
        end else if (misaligned) begin
            next_pc    = TRAP_VECTOR;
            take_trap  = 1'b1;
            trap_cause = CAUSE_MISALIGN;
        end else if (halt) begin
            // The halting instruction retires, so the PC moves past it.
            next_pc    = seq_pc;
            enter_halt = 1'b1;
        end else if (eret) begin
            next_pc     = epc;
            clear_cause = 1'b1;
        end else if (redirect) begin
            next_pc = target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core. Holds the FSM
// (BOOT/RUN/TRAP/HALT), the boot delay counter and the pc/epc/cause
// registers; next-PC selection lives in pc_sequencer_next_mux.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   stall            : freeze everything while in RUN
//   branch_*/jump*/jr* : redirect requests with targets
//   exception, eret, halt, resume : control events
//   pc, pc_valid     : instruction memory address and its validity
//   epc, cause       : saved faulting PC and exception cause
//   state            : current FSM state
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exception,
    input  logic        eret,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [1:0]  state
);

    // The reset cycle itself counts as the first BOOT cycle, so the counter
    // leaves BOOT when it reaches BOOT_CYCLES-1.
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    cause_t      cause_q, cause_d;
    logic [3:0]  boot_q, boot_d;

    logic [31:0] mux_pc;
    logic        take_trap;
    cause_t      trap_cause;
    logic        enter_halt;
    logic        clear_cause;

    pc_sequencer_next_mux #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_mux (
        .pc            (pc_q),
        .epc           (epc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .eret          (eret),
        .halt          (halt),
        .next_pc       (mux_pc),
        .take_trap     (take_trap),
        .trap_cause    (trap_cause),
        .enter_halt    (enter_halt),
        .clear_cause   (clear_cause)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        boot_d  = boot_q;

        case (state_q)
            ST_BOOT: begin
                if (boot_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    pc_d = mux_pc;
                    if (take_trap) begin
                        epc_d   = pc_q;
                        cause_d = trap_cause;
                        state_d = ST_TRAP;
                    end else if (enter_halt) begin
                        state_d = ST_HALT;
                    end else if (clear_cause) begin
                        cause_d = CAUSE_NONE;
                    end
                end
            end
            // Single bubble while the trap vector is fetched; pc already
            // holds TRAP_VECTOR from the entry edge.
            ST_TRAP: state_d = ST_RUN;
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is sampled on the clock edge here (synchronous), and
        // all state updates use non-blocking assignments so every register
        // sees the pre-edge values of the others.
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= 32'h0000_0000;
            cause_q <= CAUSE_NONE;
            boot_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            boot_q  <= boot_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign epc      = epc_q;
    assign cause    = cause_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Each tick() drives one cycle of inputs
// and queues the outputs expected after the coming clock edge; a separate
// monitor pops and compares on the following falling edge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        exception;
    logic        eret;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [1:0]  state;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0080),
        .BOOT_CYCLES  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .eret          (eret),
        .halt          (halt),
        .resume        (resume),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .epc           (epc),
        .cause         (cause),
        .state         (state)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic [1:0]  state;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares every queued expectation that is due this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("c%0d_due", mon_e.cyc), mon_e.cyc, cyc);
            check($sformatf("c%0d_pc", mon_e.cyc), pc, mon_e.pc);
            check($sformatf("c%0d_pc_valid", mon_e.cyc), {31'd0, pc_valid}, {31'd0, mon_e.valid});
            check($sformatf("c%0d_epc", mon_e.cyc), epc, mon_e.epc);
            check($sformatf("c%0d_cause", mon_e.cyc), {30'd0, cause}, {30'd0, mon_e.cause});
            check($sformatf("c%0d_state", mon_e.cyc), {30'd0, state}, {30'd0, mon_e.state});
        end
    end

    task automatic clear_inputs();
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        jr            = 1'b0;
        jr_target     = 32'h0;
        exception     = 1'b0;
        eret          = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
    endtask

    // Queue the outputs expected after the next edge, take the edge, then
    // return inputs to idle.
    task automatic tick(input logic [31:0] p, input logic v, input logic [31:0] ep,
                        input logic [1:0] c, input state_t s);
        exp_t e;
        e.cyc   = cyc + 1;
        e.pc    = p;
        e.valid = v;
        e.epc   = ep;
        e.cause = c;
        e.state = s;
        sb.push_back(e);
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();

        // 1: reset, two BOOT cycles, then sequential fetch
        reset = 1'b1; tick(32'h0, 1'b0, 32'h0, 2'd0, ST_BOOT);
        reset = 1'b1; tick(32'h0, 1'b0, 32'h0, 2'd0, ST_BOOT);
        tick(32'h0, 1'b0, 32'h0, 2'd0, ST_BOOT);
        tick(32'h0, 1'b1, 32'h0, 2'd0, ST_RUN);
        tick(32'h4, 1'b1, 32'h0, 2'd0, ST_RUN);
        tick(32'h8, 1'b1, 32'h0, 2'd0, ST_RUN);

        // 2: jump beats branch
        branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h100;
        tick(32'h100, 1'b1, 32'h0, 2'd0, ST_RUN);

        // 3: misaligned jr traps with cause 10, one TRAP bubble
        jump = 1'b1; jump_target = 32'h10;
        tick(32'h10, 1'b1, 32'h0, 2'd0, ST_RUN);
        jr = 1'b1; jr_target = 32'h22;
        tick(32'h80, 1'b0, 32'h10, 2'd2, ST_TRAP);
        tick(32'h80, 1'b1, 32'h10, 2'd2, ST_RUN);
        tick(32'h84, 1'b1, 32'h10, 2'd2, ST_RUN);

        // 4: stall freezes pc and ignores jump
        jump = 1'b1; jump_target = 32'h20;
        tick(32'h20, 1'b1, 32'h10, 2'd2, ST_RUN);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; jump = 1'b1; jump_target = 32'h200;
            tick(32'h20, 1'b1, 32'h10, 2'd2, ST_RUN);
        end
        tick(32'h24, 1'b1, 32'h10, 2'd2, ST_RUN);

        // 5: exception at 0x30, eret back, halt, ignored inputs, resume
        jump = 1'b1; jump_target = 32'h30;
        tick(32'h30, 1'b1, 32'h10, 2'd2, ST_RUN);
        exception = 1'b1;
        tick(32'h80, 1'b0, 32'h30, 2'd1, ST_TRAP);
        tick(32'h80, 1'b1, 32'h30, 2'd1, ST_RUN);
        eret = 1'b1;
        tick(32'h30, 1'b1, 32'h30, 2'd0, ST_RUN);
        tick(32'h34, 1'b1, 32'h30, 2'd0, ST_RUN);
        halt = 1'b1;
        tick(32'h38, 1'b0, 32'h30, 2'd0, ST_HALT);
        jump = 1'b1; jump_target = 32'h200; eret = 1'b1;
        tick(32'h38, 1'b0, 32'h30, 2'd0, ST_HALT);
        resume = 1'b1;
        tick(32'h38, 1'b1, 32'h30, 2'd0, ST_RUN);
        tick(32'h3C, 1'b1, 32'h30, 2'd0, ST_RUN);

        // exception wins over halt; stall ignored in TRAP
        halt = 1'b1; exception = 1'b1;
        tick(32'h80, 1'b0, 32'h3C, 2'd1, ST_TRAP);
        stall = 1'b1;
        tick(32'h80, 1'b1, 32'h3C, 2'd1, ST_RUN);
        // misaligned jump wins over eret
        eret = 1'b1; jump = 1'b1; jump_target = 32'h102;
        tick(32'h80, 1'b0, 32'h80, 2'd2, ST_TRAP);
        tick(32'h80, 1'b1, 32'h80, 2'd2, ST_RUN);
        branch_taken = 1'b1; branch_target = 32'h40;
        tick(32'h40, 1'b1, 32'h80, 2'd2, ST_RUN);
        // eret beats aligned jr
        eret = 1'b1; jr = 1'b1; jr_target = 32'h300;
        tick(32'h80, 1'b1, 32'h80, 2'd0, ST_RUN);

        // 6: wrap at top of address space, reset out of TRAP
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick(32'hFFFF_FFFC, 1'b1, 32'h80, 2'd0, ST_RUN);
        tick(32'h0, 1'b1, 32'h80, 2'd0, ST_RUN);
        exception = 1'b1;
        tick(32'h80, 1'b0, 32'h0, 2'd1, ST_TRAP);
        reset = 1'b1; jump = 1'b1; jump_target = 32'h200;
        tick(32'h0, 1'b0, 32'h0, 2'd0, ST_BOOT);
        tick(32'h0, 1'b0, 32'h0, 2'd0, ST_BOOT);
        tick(32'h0, 1'b1, 32'h0, 2'd0, ST_RUN);
        tick(32'h4, 1'b1, 32'h0, 2'd0, ST_RUN);

        repeat (2) @(posedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
